// File: rtl/fmap_collector_if.sv
// Pixel-stream and bank read-port bundle for fmap_collector.
// master: producer/reader side, slave: the collector.
interface fmap_collector_if #(
   parameter int data_width = 32,
   parameter int AW         = 9
);
   logic                  valid_in;
   logic [data_width-1:0] pxl_in;
   logic [AW-1:0]         rd_addr;
   logic                  rd_en;
   logic                  rd_release;
   logic [data_width-1:0] rd_data;
   logic                  rd_data_valid;
   logic                  map_ready;
   logic                  frame_done;
   logic [7:0]            map_count;
   logic                  all_done;
   logic                  overflow;
   logic [data_width-1:0] frame_sum;

   modport master (
      output valid_in, pxl_in, rd_addr, rd_en, rd_release,
      input  rd_data, rd_data_valid, map_ready, frame_done,
             map_count, all_done, overflow, frame_sum
   );

   modport slave (
      input  valid_in, pxl_in, rd_addr, rd_en, rd_release,
      output rd_data, rd_data_valid, map_ready, frame_done,
             map_count, all_done, overflow, frame_sum
   );
endinterface

// File: rtl/fmap_collector.sv
// Ping-pong feature-map collector: captures D*D-pixel maps into two banks with a random-access read port.
// Optional FMAP_COLLECTOR_CHECKSUM_EN adds a per-map XOR checksum on frame_sum.
module fmap_collector #(
   parameter int data_width = 32,
   parameter int D          = 17,
   parameter int C          = 10,
   parameter int AW         = 9
) (
   input logic            clk,
   input logic            reset,
   fmap_collector_if.slave bus
);
   localparam int unsigned   T         = D * D;
   localparam logic [AW-1:0] LAST_ADDR = AW'(T - 1);
   localparam logic [7:0]    MAP_MAX   = 8'(C);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_FILLING = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   logic [data_width-1:0] mem [2][2**AW];
   logic [1:0]            bank_state [2];
   logic                  wr_bank;
   logic                  rd_bank;
   logic [AW-1:0]         wr_cnt;
   logic                  accept;
   logic                  last_px;
   logic                  release_ok;
   logic                  read_ok;

   always_comb begin
      accept     = bus.valid_in && (bank_state[wr_bank] != ST_FULL);
      last_px    = accept && (wr_cnt == LAST_ADDR);
      release_ok = bus.rd_release && bus.map_ready;
      read_ok    = bus.rd_en && bus.map_ready;
   end

   assign bus.map_ready = (bank_state[rd_bank] == ST_FULL);
   assign bus.all_done  = (bus.map_count == MAP_MAX);

   // The write bank is never FULL while accepting and the read bank is always FULL when
   // released, so a completing write and a release always target different banks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned b = 0; b < 2; b++) bank_state[b] <= ST_EMPTY;
         wr_bank        <= 1'b0;
         rd_bank        <= 1'b0;
         wr_cnt         <= '0;
         bus.frame_done <= 1'b0;
         bus.map_count  <= '0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.frame_done <= last_px;
         for (int unsigned b = 0; b < 2; b++) begin
            if (accept && (wr_bank == 1'(b)))
               bank_state[b] <= last_px ? ST_FULL : ST_FILLING;
            else if (release_ok && (rd_bank == 1'(b)))
               bank_state[b] <= ST_EMPTY;
         end
         if (accept)
            wr_cnt <= last_px ? '0 : wr_cnt + AW'(1);
         if (last_px) begin
            wr_bank <= ~wr_bank;
            if (bus.map_count != MAP_MAX)
               bus.map_count <= bus.map_count + 8'd1;
         end
         if (release_ok)
            rd_bank <= ~rd_bank;
         if (bus.valid_in && !accept)
            bus.overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_bank][wr_cnt] <= bus.pxl_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rd_data       <= '0;
         bus.rd_data_valid <= 1'b0;
      end else begin
         bus.rd_data_valid <= read_ok;
         if (read_ok)
            bus.rd_data <= mem[rd_bank][bus.rd_addr];
      end
   end

`ifdef FMAP_COLLECTOR_CHECKSUM_EN
   logic [data_width-1:0] acc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc           <= '0;
         bus.frame_sum <= '0;
      end else if (accept) begin
         if (last_px) begin
            bus.frame_sum <= acc ^ bus.pxl_in;
            acc           <= '0;
         end else begin
            acc <= acc ^ bus.pxl_in;
         end
      end
   end
`else
   assign bus.frame_sum = '0;
`endif
endmodule

// File: tb/tb_fmap_collector.sv
// Directed self-checking bench for fmap_collector (D=17, C=10).
module tb_fmap_collector;
   localparam int DW = 32;
   localparam int D  = 17;
   localparam int C  = 10;
   localparam int AW = 9;
   localparam int T  = D * D;

`ifdef FMAP_COLLECTOR_CHECKSUM_EN
   localparam logic [31:0] SUM_RAMP = 32'h0000_0120;
   localparam logic [31:0] SUM_GAP  = 32'h3c23_d70a;
`else
   localparam logic [31:0] SUM_RAMP = 32'h0;
   localparam logic [31:0] SUM_GAP  = 32'h0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fmap_collector_if #(.data_width(DW), .AW(AW)) bus ();

   fmap_collector #(.data_width(DW), .D(D), .C(C), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int fd_count = 0;
   int fd_mark;
   logic [31:0] rdat;
   logic        rvld;

   always @(negedge clk) if (bus.frame_done === 1'b1) fd_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int n, input int gap, input logic [31:0] base, input bit incr);
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (gap) tick();
         bus.valid_in = 1'b1;
         bus.pxl_in   = incr ? base + 32'(i) : base;
         tick();
         bus.valid_in = 1'b0;
      end
   endtask

   task automatic read_at(input int addr, output logic [31:0] data, output logic vld);
      bus.rd_addr = AW'(addr);
      bus.rd_en   = 1'b1;
      tick();
      bus.rd_en   = 1'b0;
      data = bus.rd_data;
      vld  = bus.rd_data_valid;
   endtask

   task automatic release_bank();
      bus.rd_release = 1'b1;
      tick();
      bus.rd_release = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rd_data"},   bus.rd_data, 32'h0);
      check({tag, " rd_vld"},    32'(bus.rd_data_valid), 32'h0);
      check({tag, " map_ready"}, 32'(bus.map_ready), 32'h0);
      check({tag, " frame_done"},32'(bus.frame_done), 32'h0);
      check({tag, " map_count"}, 32'(bus.map_count), 32'h0);
      check({tag, " all_done"},  32'(bus.all_done), 32'h0);
      check({tag, " overflow"},  32'(bus.overflow), 32'h0);
      check({tag, " frame_sum"}, bus.frame_sum, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      bus.valid_in   = 1'b0;
      bus.pxl_in     = '0;
      bus.rd_addr    = '0;
      bus.rd_en      = 1'b0;
      bus.rd_release = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();

      // Single map, ramp 0..288
      stream(T - 1, 0, 32'd0, 1'b1);
      check("ramp pre frame_done", 32'(bus.frame_done), 32'h0);
      check("ramp pre map_ready",  32'(bus.map_ready), 32'h0);
      stream(1, 0, 32'd288, 1'b0);
      check("ramp frame_done", 32'(bus.frame_done), 32'h1);
      check("ramp map_ready",  32'(bus.map_ready), 32'h1);
      check("ramp map_count",  32'(bus.map_count), 32'd1);
      check("ramp frame_sum",  bus.frame_sum, SUM_RAMP);
      read_at(5, rdat, rvld);
      check("ramp rd5 data", rdat, 32'd5);
      check("ramp rd5 vld",  32'(rvld), 32'h1);
      check("ramp frame_done pulse", 32'(bus.frame_done), 32'h0);
      read_at(288, rdat, rvld);
      check("ramp rd288 data", rdat, 32'd288);
      tick();
      check("rd hold vld",  32'(bus.rd_data_valid), 32'h0);
      check("rd hold data", bus.rd_data, 32'd288);
      release_bank();
      check("ramp released", 32'(bus.map_ready), 32'h0);
      read_at(3, rdat, rvld);
      check("rd no map vld", 32'(rvld), 32'h0);

      // Gapped constant stream
      fd_mark = fd_count;
      stream(T, 2, 32'h3c23_d70a, 1'b0);
      check("gap frame_done", 32'(bus.frame_done), 32'h1);
      check("gap frame_sum",  bus.frame_sum, SUM_GAP);
      tick();
      check("gap fd pulses",  32'(fd_count - fd_mark), 32'd1);
      check("gap map_count",  32'(bus.map_count), 32'd2);
      for (int a = 0; a < T; a++) begin
         read_at(a, rdat, rvld);
         check($sformatf("gap rd%0d", a), rdat, 32'h3c23_d70a);
      end
      check("gap overflow", 32'(bus.overflow), 32'h0);
      release_bank();

      // Overflow: three maps without release
      apply_reset();
      fd_mark = fd_count;
      stream(3 * T, 0, 32'd0, 1'b1);
      tick();
      check("ovf overflow",  32'(bus.overflow), 32'h1);
      check("ovf map_count", 32'(bus.map_count), 32'd2);
      check("ovf fd pulses", 32'(fd_count - fd_mark), 32'd2);
      read_at(288, rdat, rvld);
      check("ovf bank0 rd288", rdat, 32'd288);
      release_bank();
      check("ovf map_ready bank1", 32'(bus.map_ready), 32'h1);
      read_at(0, rdat, rvld);
      check("ovf bank1 rd0", rdat, 32'd289);
      stream(T, 0, 32'd1000, 1'b1);
      check("ovf refill count", 32'(bus.map_count), 32'd3);
      check("ovf sticky",       32'(bus.overflow), 32'h1);
      release_bank();
      read_at(0, rdat, rvld);
      check("ovf refill rd0", rdat, 32'd1000);
      release_bank();
      check("ovf drained", 32'(bus.map_ready), 32'h0);

      // Last pixel of bank1 coincides with release of bank0
      apply_reset();
      stream(T, 0, 32'd2000, 1'b1);
      stream(T - 1, 0, 32'd3000, 1'b1);
      bus.valid_in   = 1'b1;
      bus.pxl_in     = 32'd3288;
      bus.rd_release = 1'b1;
      tick();
      bus.valid_in   = 1'b0;
      bus.rd_release = 1'b0;
      check("sim frame_done", 32'(bus.frame_done), 32'h1);
      check("sim map_ready",  32'(bus.map_ready), 32'h1);
      check("sim map_count",  32'(bus.map_count), 32'd2);
      read_at(0, rdat, rvld);
      check("sim bank1 rd0", rdat, 32'd3000);
      read_at(288, rdat, rvld);
      check("sim bank1 rd288", rdat, 32'd3288);
      stream(T, 0, 32'd4000, 1'b1);
      check("sim no drop",   32'(bus.overflow), 32'h0);
      check("sim count3",    32'(bus.map_count), 32'd3);
      bus.rd_release = 1'b1;
      read_at(7, rdat, rvld);
      bus.rd_release = 1'b0;
      check("rd+release data", rdat, 32'd3007);
      check("rd+release vld",  32'(rvld), 32'h1);
      check("rd+release ready", 32'(bus.map_ready), 32'h1);
      read_at(7, rdat, rvld);
      check("bank0 rd7", rdat, 32'd4007);

      // Completion, saturation, reset mid-map
      apply_reset();
      for (int m = 0; m < C; m++) begin
         stream(T, 0, 32'(m * 1000), 1'b1);
         release_bank();
      end
      check("done map_count", 32'(bus.map_count), 32'd10);
      check("done all_done",  32'(bus.all_done), 32'h1);
      stream(T, 0, 32'd0, 1'b1);
      check("sat frame_done", 32'(bus.frame_done), 32'h1);
      check("sat map_count",  32'(bus.map_count), 32'd10);
      read_at(3, rdat, rvld);
      check("sat rd3", rdat, 32'd3);
      release_bank();
      stream(100, 0, 32'd7000, 1'b1);
      #2;
      reset = 1'b0;
      #2;
      check_all_zero("midreset");
      tick();
      reset = 1'b1;
      tick();
      stream(T, 0, 32'd5000, 1'b1);
      check("post reset count", 32'(bus.map_count), 32'd1);
      check("post reset done",  32'(bus.all_done), 32'h0);
      read_at(0, rdat, rvld);
      check("post reset rd0", rdat, 32'd5000);
      read_at(288, rdat, rvld);
      check("post reset rd288", rdat, 32'd5288);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fmap_collector.md
# fmap_collector

Stream sink at the output of an inference layer (e.g. Inception-ResNet stages). Captures the layer's `valid`-qualified pixel stream, raster order, D×D pixels per feature map, into a two-bank (ping-pong) buffer. Exposes completed maps to a downstream reader through a random-access read port with explicit bank release. Counts completed maps up to C and flags loss of data.

## Interface
- `data_width`, 32: pixel width (IEEE-754 single bit pattern, treated as opaque bits)
- `D`, 17: feature-map side; T = D*D pixels per map
- `C`, 10: maps per layer run; `all_done` asserts after C maps
- `AW`, 9: read/write address width; must satisfy 2^AW ≥ T
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  pixel strobe from the layer (`valid_out` of the producer)
- `pxl_in`  in  data_width  pixel from the layer
- `rd_addr`  in  AW  read address within the current read bank, 0..T-1
- `rd_en`  in  1  read request
- `rd_release`  in  1  one-cycle pulse: reader finished with current read bank
- `rd_data`  out  data_width  read data, registered
- `rd_data_valid`  out  1  `rd_data` corresponds to the previous cycle's accepted `rd_en`
- `map_ready`  out  1  current read bank holds a complete map
- `frame_done`  out  1  one-cycle pulse per completed map
- `map_count`  out  8  completed maps since reset, saturates at C
- `all_done`  out  1  `map_count` == C
- `overflow`  out  1  sticky: a pixel was dropped
- `frame_sum`  out  data_width  only with `FMAP_COLLECTOR_CHECKSUM_EN`, see Configuration

## Operation
- Two banks of T words. Bank state per bank: EMPTY → FILLING → FULL → EMPTY.
- Writer: `wr_bank` pointer and `wr_cnt` (0..T-1). On `valid_in` with `wr_bank` not FULL: write `pxl_in` to `wr_bank[wr_cnt]`, increment `wr_cnt`. When the T-th pixel (wr_cnt == T-1) is written: bank → FULL, `wr_cnt` → 0, `wr_bank` toggles, `frame_done` pulses, `map_count` increments (saturating at C).
- `valid_in` while `wr_bank` is FULL (both banks occupied): pixel dropped, `overflow` ← 1, `wr_cnt` unchanged. `overflow` clears only on reset.
- Pixels beyond C maps are still captured normally; `map_count` holds at C.
- Reader: `rd_bank` pointer, oldest FULL bank. `map_ready` = (`rd_bank` is FULL).
- `rd_en` accepted only when `map_ready`; `rd_en` without `map_ready` is ignored (`rd_data_valid` stays 0). `rd_addr` ≥ T returns undefined data; `rd_data_valid` still asserts.
- `rd_release` with `map_ready`: `rd_bank` → EMPTY, `rd_bank` toggles. `rd_release` without `map_ready` ignored.
- Simultaneous events:
  - T-th write to one bank and release of the other: both take effect same edge.
  - Release and dropped pixel same cycle: pixel stays dropped; freed bank is writable from the next cycle.
  - `rd_en` and `rd_release` same cycle: read returns data from the bank being released.
- `valid_in` may have arbitrary gaps; only accepted pixels advance `wr_cnt`.

## Timing
- Reset (async, `reset` = 0): both banks EMPTY, `wr_bank` = `rd_bank` = 0, `wr_cnt` = 0; outputs `rd_data` = 0, `rd_data_valid` = 0, `map_ready` = 0, `frame_done` = 0, `map_count` = 0, `all_done` = 0, `overflow` = 0, `frame_sum` = 0. Buffer contents not cleared. Reset mid-map discards the partial map.
- Write latency: a pixel accepted at edge N is readable from edge N+1 once its bank is FULL.
- `frame_done`, `map_ready`, and the `map_count` increment are all registered at the edge that writes the T-th pixel; visible in the cycle after it.
- Read latency 1: `rd_en` sampled at edge N gives `rd_data`/`rd_data_valid` after edge N; `rd_data` holds until the next accepted read.
- `map_ready` deasserts the cycle after an accepted `rd_release`, or stays 1 if the other bank is already FULL (`rd_bank` toggled).
- Sustained throughput: one pixel per clock, no bubbles, provided the reader releases within T cycles.

## Configuration
- `FMAP_COLLECTOR_CHECKSUM_EN` defined:
  - `frame_sum` is the bitwise XOR of all accepted pixels of the most recently completed map, updated with `frame_done`.
  - The running accumulator restarts at 0 for each map.
  - Dropped pixels are excluded.
- Not defined: no accumulator logic; `frame_sum` is tied to 0.

## Test plan
- Single map: D=17, 289 consecutive pixels with values 0..288 → `frame_done` pulse the cycle after pixel 288; `map_ready` = 1; read addr 5 → `rd_data` = 5 with `rd_data_valid` one cycle later; read addr 288 → 288.
- Gapped stream: `valid_in` every 3rd cycle, 289 pixels of 0x3c23d70a → one `frame_done`; all addresses read back 0x3c23d70a; `overflow` = 0.
- Overflow: 3×289 pixels, no release → maps 0 and 1 FULL, all 289 pixels of the third map dropped; `overflow` = 1; `map_count` = 2; release one bank, then stream 289 more → `map_count` = 3.
- Simultaneous: release bank 0 on the same edge as the T-th pixel of bank 1 → `map_ready` stays 1, `rd_bank` = 1, next 289 pixels go to bank 0 without drop.
- Completion and reset: stream 10 maps with a release after each → `all_done` = 1, `map_count` = 10. Then assert `reset` low mid-way through an 11th map → all outputs 0; a following full map yields `map_count` = 1.
- Checksum (macro on): pixels 0..288 → `frame_sum` = XOR(0..288) = 0x120 after `frame_done`; macro off → `frame_sum` = 0.
